// File: rtl/pu_io_req_tracker_pkg.sv
// rtl/pu_io_req_tracker_pkg.sv - shared types, codes and error indices for the PU I/O request tracker
`ifndef NUM_OF_PU
`define NUM_OF_PU 8
`endif
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 19:17
`endif
`ifndef RESET_SIG
`define RESET_SIG rstn
`endif
`ifndef PU_SWITCH_INFO_MEM
`define PU_SWITCH_INFO_MEM 3'd0
`endif
`ifndef PU_ACTION_MEM
`define PU_ACTION_MEM 3'd1
`endif
`ifndef PU_COUNTER_MEM
`define PU_COUNTER_MEM 3'd2
`endif
`ifndef PU_METER_MEM
`define PU_METER_MEM 3'd3
`endif

package type_package;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } io_type;

  typedef enum logic [1:0] {
    PU_IO_IDLE,
    PU_IO_WAIT,
    PU_IO_ERRACK
  } pu_io_state_e;

  localparam int ERR_BAD_TGT = 0;
  localparam int ERR_OVERLAP = 1;
  localparam int ERR_DUP     = 2;
  localparam int ERR_STRAY   = 3;
  localparam int ERR_TIMEOUT = 4;
  localparam int ERR_NBITS   = 5;

  // Sliced down to the ack data width by users.
  localparam logic [255:0] PU_IO_ERR_DATA = '1;

endpackage

// File: rtl/pu_io_req_tracker_slot.sv
// rtl/pu_io_req_tracker_slot.sv - one PU's request FSM, ack mux and error detection
// Optional timeout counter enabled by PU_IO_TIMEOUT_EN.
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 19:17
`endif
`ifndef RESET_SIG
`define RESET_SIG rstn
`endif

module pu_io_req_slot
  import type_package::*;
#(
  parameter int NUM_OF_TGT    = 4,
  parameter int WIDTH_NBITS   = 32,
  parameter int TIMEOUT_NBITS = 10
) (
  input  logic                   clk,
  input  logic                   `RESET_SIG,
  input  logic                   req,
  input  io_type                 cmd,
  input  logic [NUM_OF_TGT-1:0]  tgt_ack,
  input  logic [WIDTH_NBITS-1:0] tgt_ack_data [NUM_OF_TGT],
  output logic                   io_req,
  output io_type                 io_cmd,
  output logic                   ack,
  output logic [WIDTH_NBITS-1:0] ack_data,
  output logic                   busy,
  output logic [ERR_NBITS-1:0]   err_ev
);

  localparam int TGT_IDX_NBITS = (NUM_OF_TGT > 1) ? $clog2(NUM_OF_TGT) : 1;

  pu_io_state_e             state_q, state_d;
  logic [TGT_IDX_NBITS-1:0] tgt_q, tgt_d;
  logic                     io_req_d;
  io_type                   io_cmd_d;
  logic                     ack_d;
  logic [WIDTH_NBITS-1:0]   ack_data_d;
  logic [31:0]              req_code;
  logic                     code_ok;
  logic                     tgt_hit;
  logic                     timeout_hit;
  logic [TIMEOUT_NBITS-1:0] tmo_cnt;

  assign req_code = 32'(cmd.addr[`PU_MEM_MULTI_DEPTH_RANGE]);
  assign code_ok  = req_code < NUM_OF_TGT;
  assign tgt_hit  = tgt_ack[tgt_q];
  // The ack cycle still counts as busy so a request landing on it is an overlap.
  assign busy     = (state_q != PU_IO_IDLE) || ack;

`ifdef PU_IO_TIMEOUT_EN
  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) begin
      tmo_cnt <= '0;
    end else if (state_q == PU_IO_WAIT && state_d == PU_IO_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_cnt = '0;
`endif

  assign timeout_hit = (state_q == PU_IO_WAIT) && (&tmo_cnt);

  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) begin
      state_q  <= PU_IO_IDLE;
      tgt_q    <= '0;
      io_req   <= 1'b0;
      io_cmd   <= '0;
      ack      <= 1'b0;
      ack_data <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      io_req   <= io_req_d;
      io_cmd   <= io_cmd_d;
      ack      <= ack_d;
      ack_data <= ack_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    io_req_d   = 1'b0;
    io_cmd_d   = io_cmd;
    ack_d      = 1'b0;
    ack_data_d = '0;
    err_ev     = '0;

    case (state_q)
      PU_IO_IDLE: begin
        if (req && !ack) begin
          io_cmd_d = cmd;
          tgt_d    = req_code[TGT_IDX_NBITS-1:0];
          if (code_ok) begin
            io_req_d = 1'b1;
            state_d  = PU_IO_WAIT;
          end else begin
            err_ev[ERR_BAD_TGT] = 1'b1;
            state_d             = PU_IO_ERRACK;
          end
        end
      end
      PU_IO_WAIT: begin
        // A genuine ack beats a timeout expiring in the same cycle.
        if (tgt_hit) begin
          ack_d      = 1'b1;
          ack_data_d = tgt_ack_data[tgt_q];
          state_d    = PU_IO_IDLE;
        end else if (timeout_hit) begin
          err_ev[ERR_TIMEOUT] = 1'b1;
          ack_d               = 1'b1;
          ack_data_d          = PU_IO_ERR_DATA[WIDTH_NBITS-1:0];
          state_d             = PU_IO_IDLE;
        end
      end
      PU_IO_ERRACK: begin
        ack_d      = 1'b1;
        ack_data_d = PU_IO_ERR_DATA[WIDTH_NBITS-1:0];
        state_d    = PU_IO_IDLE;
      end
      default: state_d = PU_IO_IDLE;
    endcase

    if (req && busy) begin
      err_ev[ERR_OVERLAP] = 1'b1;
    end

    if (state_q != PU_IO_WAIT) begin
      if (|tgt_ack) err_ev[ERR_STRAY] = 1'b1;
    end else if ($countones(tgt_ack) > 1) begin
      err_ev[ERR_DUP] = 1'b1;
    end else if ((|tgt_ack) && !tgt_hit) begin
      err_ev[ERR_STRAY] = 1'b1;
    end
  end

endmodule

// File: rtl/pu_io_req_tracker.sv
// rtl/pu_io_req_tracker.sv - per-PU request tracking and ack merge for the shared PU I/O bus
// Optional per-PU timeout enabled by PU_IO_TIMEOUT_EN.
`ifndef NUM_OF_PU
`define NUM_OF_PU 8
`endif
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif
`ifndef RESET_SIG
`define RESET_SIG rstn
`endif

module pu_io_req_tracker
  import type_package::*;
#(
  parameter int NUM_OF_PU     = `NUM_OF_PU,
  parameter int WIDTH_NBITS   = `PU_WIDTH_NBITS,
  parameter int NUM_OF_TGT    = 4,
  parameter int TIMEOUT_NBITS = 10
) (
  input  logic                   clk,
  input  logic                   `RESET_SIG,
  input  logic [NUM_OF_PU-1:0]   pu_io_req,
  input  io_type                 pu_io_cmd [NUM_OF_PU],
  output logic [NUM_OF_PU-1:0]   io_req,
  output io_type                 io_cmd [NUM_OF_PU],
  input  logic [NUM_OF_PU-1:0]   tgt_io_ack [NUM_OF_TGT],
  input  logic [WIDTH_NBITS-1:0] tgt_io_ack_data [NUM_OF_TGT][NUM_OF_PU],
  output logic [NUM_OF_PU-1:0]   pu_io_ack,
  output logic [WIDTH_NBITS-1:0] pu_io_ack_data [NUM_OF_PU],
  output logic [NUM_OF_PU-1:0]   pu_io_busy,
  output logic [ERR_NBITS-1:0]   err_sticky
);

  logic [NUM_OF_TGT-1:0]  slot_ack      [NUM_OF_PU];
  logic [WIDTH_NBITS-1:0] slot_ack_data [NUM_OF_PU][NUM_OF_TGT];
  logic [ERR_NBITS-1:0]   slot_err      [NUM_OF_PU];
  logic [ERR_NBITS-1:0]   err_any;

  for (genvar p = 0; p < NUM_OF_PU; p++) begin : g_pu
    // Targets present per-target vectors; each slot wants its own column.
    for (genvar t = 0; t < NUM_OF_TGT; t++) begin : g_tgt
      assign slot_ack[p][t]      = tgt_io_ack[t][p];
      assign slot_ack_data[p][t] = tgt_io_ack_data[t][p];
    end

    pu_io_req_slot #(
      .NUM_OF_TGT    (NUM_OF_TGT),
      .WIDTH_NBITS   (WIDTH_NBITS),
      .TIMEOUT_NBITS (TIMEOUT_NBITS)
    ) u_slot (
      .clk          (clk),
      .`RESET_SIG   (`RESET_SIG),
      .req          (pu_io_req[p]),
      .cmd          (pu_io_cmd[p]),
      .tgt_ack      (slot_ack[p]),
      .tgt_ack_data (slot_ack_data[p]),
      .io_req       (io_req[p]),
      .io_cmd       (io_cmd[p]),
      .ack          (pu_io_ack[p]),
      .ack_data     (pu_io_ack_data[p]),
      .busy         (pu_io_busy[p]),
      .err_ev       (slot_err[p])
    );
  end

  always_comb begin
    err_any = '0;
    for (int p = 0; p < NUM_OF_PU; p++) begin
      err_any = err_any | slot_err[p];
    end
  end

  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= err_sticky | err_any;
    end
  end

endmodule

// File: tb/tb_pu_io_req_tracker.sv
// tb/tb_pu_io_req_tracker.sv - scoreboard bench for pu_io_req_tracker
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 19:17
`endif

module tb_pu_io_req_tracker;
  import type_package::*;

  localparam int NP = 8;
  localparam int NT = 4;
  localparam int W  = 32;
  localparam int TN = 4;
  localparam logic [W-1:0] ERRD = '1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NP-1:0] pu_io_req;
  io_type        pu_io_cmd [NP];
  logic [NP-1:0] io_req;
  io_type        io_cmd [NP];
  logic [NP-1:0] tgt_io_ack [NT];
  logic [W-1:0]  tgt_io_ack_data [NT][NP];
  logic [NP-1:0] pu_io_ack;
  logic [W-1:0]  pu_io_ack_data [NP];
  logic [NP-1:0] pu_io_busy;
  logic [4:0]    err_sticky;

  pu_io_req_tracker #(
    .NUM_OF_PU(NP), .WIDTH_NBITS(W), .NUM_OF_TGT(NT), .TIMEOUT_NBITS(TN)
  ) dut (
    .clk(clk), .rstn(rstn), .pu_io_req(pu_io_req), .pu_io_cmd(pu_io_cmd),
    .io_req(io_req), .io_cmd(io_cmd), .tgt_io_ack(tgt_io_ack),
    .tgt_io_ack_data(tgt_io_ack_data), .pu_io_ack(pu_io_ack),
    .pu_io_ack_data(pu_io_ack_data), .pu_io_busy(pu_io_busy), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q [NP][$];
  int   io_req_cnt [NP];
  int   busy_cnt [NP];

  localparam logic [4:0] M_BAD  = 5'b00001;
  localparam logic [4:0] M_OVL  = 5'b00010;
  localparam logic [4:0] M_DUP  = 5'b00100;
  localparam logic [4:0] M_STR  = 5'b01000;
  localparam logic [4:0] M_TMO  = 5'b10000;

  always @(negedge clk) begin : mon
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      if (io_req[p]) io_req_cnt[p]++;
      if (pu_io_busy[p]) busy_cnt[p]++;
      n_cmp++;
      if (pu_io_ack[p]) begin
        if (exp_q[p].size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_ack pu=%0d cyc=%0d got data=%h, required no ack", p, cyc, pu_io_ack_data[p]);
        end else begin
          e = exp_q[p].pop_front();
          if (pu_io_ack_data[p] !== e.data || cyc !== e.cyc) begin
            n_mis++;
            $display("FAIL ack pu=%0d got data=%h cyc=%0d, required data=%h cyc=%0d",
                     p, pu_io_ack_data[p], cyc, e.data, e.cyc);
          end
        end
      end else if (pu_io_ack_data[p] !== '0) begin
        n_mis++;
        $display("FAIL idle_data pu=%0d got %h, required 0", p, pu_io_ack_data[p]);
      end
    end
  end

  function automatic logic [31:0] mk_addr(input logic [2:0] code);
    logic [31:0] a;
    a = 32'h0000_0040;
    a[`PU_MEM_MULTI_DEPTH_RANGE] = code;
    return a;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < NP; p++) s += exp_q[p].size();
    return s;
  endfunction

  task automatic clear_pulses();
    pu_io_req = '0;
    for (int t = 0; t < NT; t++) tgt_io_ack[t] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_pulses();
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      io_req_cnt[p] = 0;
      busy_cnt[p]   = 0;
    end
    rstn = 1'b1;
  endtask

  task automatic send_req(input int p, input logic [2:0] code, input logic wr);
    pu_io_cmd[p] = '{wr: wr, addr: mk_addr(code), data: 32'hC0DE_0000 | 32'(p)};
    pu_io_req[p] = 1'b1;
  endtask

  task automatic send_ack(input int t, input int p, input logic [W-1:0] d, input bit expect_it);
    exp_t e;
    tgt_io_ack[t][p]      = 1'b1;
    tgt_io_ack_data[t][p] = d;
    if (expect_it) begin
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q[p].push_back(e);
    end
  endtask

  task automatic push_err_ack(input int p, input int at);
    exp_t e;
    e.data = ERRD;
    e.cyc  = at;
    exp_q[p].push_back(e);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_pulses();
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 5;
    if (io_req !== '0) begin n_mis++; $display("FAIL rst_io_req got %h, required 0", io_req); end
    if (pu_io_busy !== '0) begin n_mis++; $display("FAIL rst_busy got %h, required 0", pu_io_busy); end
    if (err_sticky !== '0) begin n_mis++; $display("FAIL rst_err got %b, required 0", err_sticky); end
    if (io_cmd[3] !== '0) begin n_mis++; $display("FAIL rst_io_cmd got %h, required 0", io_cmd[3]); end
    if (pu_io_ack !== '0) begin n_mis++; $display("FAIL rst_ack got %h, required 0", pu_io_ack); end
  endtask

  task automatic test_single_read();
    io_type exp_cmd;
    do_reset();
    send_req(3, `PU_SWITCH_INFO_MEM, 1'b0);
    exp_cmd = pu_io_cmd[3];
    step();
    n_cmp += 2;
    if (io_req !== 8'b0000_1000) begin n_mis++; $display("FAIL single_io_req got %b, required 00001000", io_req); end
    if (io_cmd[3] !== exp_cmd) begin n_mis++; $display("FAIL single_io_cmd got %h, required %h", io_cmd[3], exp_cmd); end
    repeat (5) step();
    send_ack(0, 3, 32'h1234, 1'b1);
    step();
    repeat (3) step();
    n_cmp += 4;
    if (busy_cnt[3] !== 7) begin n_mis++; $display("FAIL single_busy got %0d, required 7", busy_cnt[3]); end
    if (io_req_cnt[3] !== 1) begin n_mis++; $display("FAIL single_req_cnt got %0d, required 1", io_req_cnt[3]); end
    if (err_sticky !== '0) begin n_mis++; $display("FAIL single_err got %b, required 0", err_sticky); end
    if (pending() !== 0) begin n_mis++; $display("FAIL single_pending got %0d, required 0", pending()); end
  endtask

  task automatic test_all_pus();
    do_reset();
    for (int p = 0; p < NP; p++) send_req(p, 3'(p % NT), 1'(p & 1));
    step();
    n_cmp++;
    if (io_req !== 8'hFF) begin n_mis++; $display("FAIL all_io_req got %h, required ff", io_req); end
    step();
    for (int p = NP - 1; p >= 0; p--) begin
      send_ack(p % NT, p, 32'hA000_0000 | 32'(p), 1'b1);
      step();
    end
    repeat (3) step();
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (io_req_cnt[p] !== 1) begin n_mis++; $display("FAIL all_req_cnt pu=%0d got %0d, required 1", p, io_req_cnt[p]); end
    end
    n_cmp += 2;
    if (err_sticky !== '0) begin n_mis++; $display("FAIL all_err got %b, required 0", err_sticky); end
    if (pending() !== 0) begin n_mis++; $display("FAIL all_pending got %0d, required 0", pending()); end
  endtask

  task automatic test_bad_tgt();
    do_reset();
    send_req(2, 3'(NT), 1'b1);
    push_err_ack(2, cyc + 2);
    step();
    n_cmp += 2;
    if (io_req !== '0) begin n_mis++; $display("FAIL bad_io_req got %h, required 0", io_req); end
    if (pu_io_busy[2] !== 1'b1) begin n_mis++; $display("FAIL bad_busy got %b, required 1", pu_io_busy[2]); end
    repeat (4) step();
    n_cmp += 3;
    if (io_req_cnt[2] !== 0) begin n_mis++; $display("FAIL bad_req_cnt got %0d, required 0", io_req_cnt[2]); end
    if (err_sticky !== M_BAD) begin n_mis++; $display("FAIL bad_err got %b, required %b", err_sticky, M_BAD); end
    if (pending() !== 0) begin n_mis++; $display("FAIL bad_pending got %0d, required 0", pending()); end
  endtask

  task automatic test_overlap();
    do_reset();
    send_req(0, `PU_ACTION_MEM, 1'b0);
    step();
    step();
    send_req(0, `PU_COUNTER_MEM, 1'b1);
    step();
    send_ack(1, 0, 32'h55, 1'b1);
    step();
    repeat (3) step();
    n_cmp += 3;
    if (io_req_cnt[0] !== 1) begin n_mis++; $display("FAIL ovl_req_cnt got %0d, required 1", io_req_cnt[0]); end
    if (err_sticky !== M_OVL) begin n_mis++; $display("FAIL ovl_err got %b, required %b", err_sticky, M_OVL); end
    if (pending() !== 0) begin n_mis++; $display("FAIL ovl_pending got %0d, required 0", pending()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_req(5, `PU_COUNTER_MEM, 1'b0);
    step();
    send_ack(2, 5, 32'h77, 1'b1);
    step();
    send_req(5, `PU_ACTION_MEM, 1'b0);
    step();
    n_cmp++;
    if (err_sticky !== M_OVL) begin n_mis++; $display("FAIL b2b_ack_cycle_err got %b, required %b", err_sticky, M_OVL); end
    send_req(5, `PU_METER_MEM, 1'b1);
    step();
    n_cmp += 2;
    if (io_req[5] !== 1'b1) begin n_mis++; $display("FAIL b2b_io_req got %b, required 1", io_req[5]); end
    if (io_cmd[5].addr !== mk_addr(`PU_METER_MEM)) begin n_mis++; $display("FAIL b2b_addr got %h, required %h", io_cmd[5].addr, mk_addr(`PU_METER_MEM)); end
    send_ack(3, 5, 32'h88, 1'b1);
    step();
    repeat (3) step();
    n_cmp += 3;
    if (io_req_cnt[5] !== 2) begin n_mis++; $display("FAIL b2b_req_cnt got %0d, required 2", io_req_cnt[5]); end
    if (err_sticky !== M_OVL) begin n_mis++; $display("FAIL b2b_err got %b, required %b", err_sticky, M_OVL); end
    if (pending() !== 0) begin n_mis++; $display("FAIL b2b_pending got %0d, required 0", pending()); end
  endtask

  task automatic test_dup();
    do_reset();
    send_req(1, `PU_COUNTER_MEM, 1'b0);
    step();
    step();
    send_ack(2, 1, 32'h22, 1'b1);
    send_ack(0, 1, 32'hDD, 1'b0);
    step();
    repeat (3) step();
    n_cmp += 3;
    if (err_sticky[ERR_DUP] !== 1'b1) begin n_mis++; $display("FAIL dup_bit got %b, required 1", err_sticky[ERR_DUP]); end
    if ((err_sticky & (M_BAD | M_OVL | M_TMO)) !== '0) begin n_mis++; $display("FAIL dup_other_err got %b, required no bad/ovl/tmo", err_sticky); end
    if (pending() !== 0) begin n_mis++; $display("FAIL dup_pending got %0d, required 0", pending()); end
  endtask

  task automatic test_stray();
    do_reset();
    send_ack(1, 6, 32'h66, 1'b0);
    step();
    repeat (2) step();
    n_cmp++;
    if (err_sticky !== M_STR) begin n_mis++; $display("FAIL stray_idle_err got %b, required %b", err_sticky, M_STR); end
    do_reset();
    send_req(4, `PU_SWITCH_INFO_MEM, 1'b0);
    send_ack(0, 4, 32'h99, 1'b0);
    step();
    step();
    n_cmp++;
    if (err_sticky !== M_STR) begin n_mis++; $display("FAIL stray_same_cycle_err got %b, required %b", err_sticky, M_STR); end
    send_ack(0, 4, 32'h44, 1'b1);
    step();
    repeat (3) step();
    n_cmp++;
    if (pending() !== 0) begin n_mis++; $display("FAIL stray_pending got %0d, required 0", pending()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_req(4, `PU_ACTION_MEM, 1'b0);
    step();
    step();
    rstn = 1'b0;
    step();
    n_cmp++;
    if (pu_io_busy !== '0) begin n_mis++; $display("FAIL rmid_busy got %h, required 0", pu_io_busy); end
    rstn = 1'b1;
    send_ack(1, 4, 32'h4444, 1'b0);
    step();
    repeat (3) step();
    n_cmp += 2;
    if (err_sticky !== M_STR) begin n_mis++; $display("FAIL rmid_err got %b, required %b", err_sticky, M_STR); end
    if (pending() !== 0) begin n_mis++; $display("FAIL rmid_pending got %0d, required 0", pending()); end
  endtask

`ifdef PU_IO_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    send_req(7, `PU_METER_MEM, 1'b0);
    push_err_ack(7, cyc + 1 + (1 << TN));
    step();
    repeat (1 << TN) step();
    step();
    n_cmp += 2;
    if (err_sticky !== M_TMO) begin n_mis++; $display("FAIL tmo_err got %b, required %b", err_sticky, M_TMO); end
    if (pending() !== 0) begin n_mis++; $display("FAIL tmo_pending got %0d, required 0", pending()); end
    send_ack(3, 7, 32'h7777, 1'b0);
    step();
    step();
    n_cmp++;
    if (err_sticky !== (M_TMO | M_STR)) begin n_mis++; $display("FAIL tmo_late_err got %b, required %b", err_sticky, M_TMO | M_STR); end
  endtask
`endif

  initial begin
    pu_io_req = '0;
    for (int p = 0; p < NP; p++) begin
      pu_io_cmd[p]  = '0;
      io_req_cnt[p] = 0;
      busy_cnt[p]   = 0;
    end
    for (int t = 0; t < NT; t++) begin
      tgt_io_ack[t] = '0;
      for (int p = 0; p < NP; p++) tgt_io_ack_data[t][p] = '0;
    end
    test_reset();
    test_single_read();
    test_all_pus();
    test_bad_tgt();
    test_overlap();
    test_back_to_back();
    test_dup();
    test_stray();
    test_reset_mid();
`ifdef PU_IO_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d, required bench completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/pu_io_req_tracker.md
# pu_io_req_tracker

Per-PU I/O request tracker between the processing units and the PU memory slaves (switch-info memory and its siblings on the shared PU I/O bus). It registers each PU's `io_req`/`io_cmd` and broadcasts them to all targets. It enforces one outstanding request per PU and merges the per-target `io_ack`/`io_ack_data` vectors back into a single ack per PU. It also flags protocol errors: unknown target, duplicate ack, stray ack, and optional timeout.

## Interface
Parameters:
- `NUM_OF_PU`, default `` `NUM_OF_PU ``: number of processing units.
- `WIDTH_NBITS`, default `` `PU_WIDTH_NBITS ``: ack data width.
- `NUM_OF_TGT`, default 4: number of memory targets; target code i is the value of `addr[`PU_MEM_MULTI_DEPTH_RANGE]`.
- `TIMEOUT_NBITS`, default 10: width of the per-PU timeout counter.

Ports:
- `clk`  in  1: sole clock.
- `` `RESET_SIG `` (rstn)  in  1: asynchronous, active-low reset.
- `pu_io_req`  in  NUM_OF_PU: single-cycle request pulse per PU.
- `pu_io_cmd`  in  io_type[NUM_OF_PU]: command, valid with `pu_io_req`.
- `io_req`  out  NUM_OF_PU: registered request, broadcast to all targets.
- `io_cmd`  out  io_type[NUM_OF_PU]: registered command, held until the next accepted request.
- `tgt_io_ack`  in  [NUM_OF_TGT][NUM_OF_PU]: per-target ack vectors.
- `tgt_io_ack_data`  in  [NUM_OF_TGT][NUM_OF_PU][WIDTH_NBITS]: per-target ack data.
- `pu_io_ack`  out  NUM_OF_PU: merged ack pulse to each PU.
- `pu_io_ack_data`  out  [NUM_OF_PU][WIDTH_NBITS]: merged data; 0 when no ack.
- `pu_io_busy`  out  NUM_OF_PU: request outstanding.
- `err_sticky`  out  5: sticky error bits {timeout, stray, dup, overlap, bad_tgt}; cleared only by reset.

## Operation
- Per-PU FSM has three states: IDLE, WAIT, ERRACK.
- IDLE + `pu_io_req`:
  - Latch the cmd and target code.
  - If code < NUM_OF_TGT: assert `io_req` next cycle and go to WAIT.
  - Otherwise: set bad_tgt, do not forward, and go to ERRACK.
- WAIT:
  - Accept an ack only from the latched target.
  - On that target's ack: pulse `pu_io_ack` with its data and go to IDLE.
  - Acks from other targets for this PU set stray and are dropped.
  - Two or more acks in the same cycle set dup; the latched target's ack is still delivered.
- ERRACK: issue one `pu_io_ack` with data all-ones, then go to IDLE.
- `pu_io_req` while busy (WAIT or ERRACK): set overlap, drop the request, no state change.
- Any ack for a PU in IDLE sets stray and is dropped.
- PUs are fully independent; no arbitration in this block.
- Every request receives exactly one ack, whether read or write.

## Timing
- Reset values: all outputs 0; `io_cmd` 0; all FSMs IDLE; timeout counters 0.
- `pu_io_req` at cycle T → `io_req` at T+1, 1 cycle wide.
- Target ack at cycle A → `pu_io_ack` and `pu_io_ack_data` at A+1.
- `pu_io_busy` is high from T+1 through the `pu_io_ack` cycle inclusive.
- A new request is accepted in the cycle after `pu_io_ack`. A request in the same cycle as `pu_io_ack` counts as an overlap and is dropped.
- Bad target: `pu_io_ack` at T+2.
- An ack arriving in the same cycle as the request (at T) is stray.
- Reset mid-transaction: state is abandoned. A late target ack after reset is stray.

## Configuration
- `PU_IO_TIMEOUT_EN` defined:
  - Per-PU counter runs in WAIT and clears on leaving WAIT.
  - At all-ones count (2^TIMEOUT_NBITS−1 cycles after entering WAIT): set timeout, pulse `pu_io_ack` with data all-ones the next cycle, go to IDLE.
  - A later ack from that target is stray.
  - A timeout and a genuine ack in the same cycle: the genuine ack wins and no error is raised.
- Macro undefined: no counters, timeout bit tied 0, WAIT persists indefinitely.

## Structure
- `type_package` holds:
  - `io_type`;
  - the tracker state enum;
  - the error-bit index localparams;
  - `PU_IO_ERR_DATA` (all-ones).
- Target code constants (`` `PU_SWITCH_INFO_MEM `` etc.) stay in defines.vh.
- Natural sub-module `pu_io_req_slot`: one per-PU FSM, counter and ack mux, instantiated NUM_OF_PU times in a generate loop.

## Test plan
- Single read, PU 3 → switch-info code, target acks 5 cycles later with 0x1234 → `pu_io_ack[3]` 1 cycle after the target ack with data 0x1234; busy high for 7 cycles; no errors.
- All PUs request simultaneously to mixed targets, acks returned in reverse order → each PU gets its own data; no cross-talk.
- Code = NUM_OF_TGT → no `io_req`; ack at T+2 with all-ones; bad_tgt set.
- Second request from PU 0 while in WAIT → overlap set; exactly one `io_req`; first ack delivered normally.
- Two targets ack PU 1 in the same cycle → dup set; latched target's data delivered.
- With `PU_IO_TIMEOUT_EN`, TIMEOUT_NBITS=4, target never acks → ack with all-ones at 16 cycles after `io_req`; timeout set; a late target ack sets stray.
